bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//   MM:SS stopwatch counting one step per rising edge of the divided clock
//   (1 Hz clk_div from the clock divider, fed in on tick_in).
//   Start/stop and clear come from already-debounced board push-buttons.
//   Four BCD digits go out to the 7-segment display driver.
//   Whole block runs on the main clk; tick_in is treated as a data input,
//   never as a clock.
// PARAMETERS
//   MIN_LIMIT  59  highest minutes value before wrap; legal range 1..99
//   TICK_SYNC  1   1 = tick_in goes through a 2-FF synchronizer; 0 = tick_in
//                  is already clk-synchronous (edge detector only)
// PORTS
//   clk         in   1  main system clock (e.g. 50 MHz)
//   reset       in   1  asynchronous, active-low reset (0 = reset)
//   tick_in     in   1  divided clock level; each rising edge = one second
//   start_stop  in   1  debounced button level; each rising edge toggles run/pause
//   clear       in   1  debounced button level; high = zero the count, go idle
//   sec_ones    out  4  BCD seconds units, 0..9
//   sec_tens    out  4  BCD seconds tens, 0..5
//   min_ones    out  4  BCD minutes units, 0..9
//   min_tens    out  4  BCD minutes tens, 0..9 (bounded by MIN_LIMIT)
//   running     out  1  1 while state == RUN
//   wrap        out  1  one-clk pulse on the MIN_LIMIT:59 -> 00:00 rollover
// BEHAVIOUR
//   Reset (reset==0, async)
//   - All digits 0, running 0, wrap 0, state IDLE.
//   - All synchronizer and edge-detect flops cleared.
//   - A reset mid-count is immediate and loses the count.
//   Input conditioning
//   - start_stop and clear each pass a 2-FF synchronizer. tick_in does too
//     when TICK_SYNC=1.
//   - Edge flag = sync_q & ~prev_q.
//   - Latency, TICK_SYNC=1: input rises before clk edge k -> counter updates
//     at edge k+2 (visible after edge k+2). TICK_SYNC=0: edge k+1.
//     start_stop always has the TICK_SYNC=1 latency.
//   - clear is level-sensitive after synchronization.
//   State machine (states IDLE, RUN, PAUSE)
//   - IDLE  --ss_edge-->  RUN
//   - RUN   --ss_edge-->  PAUSE
//   - PAUSE --ss_edge-->  RUN
//   - any state with clear_s=1 --> IDLE, digits forced to 0 while clear_s high
//   - IDLE always holds 00:00.
//   - PAUSE holds the current value; tick edges are ignored.
//   Counting (RUN and tick_edge, evaluated per clk)
//   - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes.
//   - Minutes count in BCD: min_ones 9->0 carries into min_tens.
//   - At minutes == MIN_LIMIT and seconds == 59, the next step goes to 00:00
//     and wrap pulses high for exactly one clk. The count keeps running.
//   - No digit ever holds a non-BCD value.
//   Simultaneous events
//   - clear with anything: clear wins; no increment, no wrap pulse.
//   - RUN with tick_edge and ss_edge in the same cycle: increment is applied,
//     next state is PAUSE.
//   - PAUSE/IDLE with tick_edge and ss_edge: no increment, next state RUN.
//   - start_stop held high: counts as one edge only.
// TESTING
//   1. Reset released, idle, 5 tick edges -> digits stay 00:00, running=0.
//   2. ss press, 75 ticks (TICK_SYNC=1) -> 01:15, running=1; each update
//      lands 3 clk edges after its tick_in rise.
//   3. RUN at 00:42, ss press, 10 ticks -> holds 00:42, running=0;
//      ss again, 1 tick -> 00:43.
//   4. Preload to MIN_LIMIT:59 (59:59 at default), 1 tick -> 00:00, wrap high
//      exactly 1 clk, running stays 1.
//      MIN_LIMIT=1: 01:59 + 1 tick -> 00:00.
//   5. clear and tick rise on the same clk while RUN at 12:34 -> 00:00, IDLE,
//      no wrap. Clear held 4 clk blocks any count. ss after release -> RUN.
//   6. reset asserted between clk edges at 03:07 -> outputs 0 immediately,
//      with no clk edge needed; after release, state is IDLE.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch running on the main clock.
// tick_in (1 Hz divided clock level), start_stop and clear are sampled as data,
// synchronized, and edge-detected. A three-state FSM (IDLE/RUN/PAUSE) gates
// counting. Minutes wrap after MIN_LIMIT:59 with a one-clock wrap pulse.
//
// Input conditioning (all signals are levels; "edge" = sync_q & ~prev_q):
//   start_stop, clear : 2-FF synchronizer, then the edge/level is used.
//   tick_in           : 2-FF synchronizer when TICK_SYNC=1, a single
//                       registering stage when TICK_SYNC=0 (input is already
//                       clk-synchronous). A rise ahead of clk edge k updates the
//                       count at edge k+2 (TICK_SYNC=1) or at edge k+1 (TICK_SYNC=0).
// clear is level-sensitive and overrides everything else in the same cycle.
// MIN_LIMIT is expected to lie in 1..99.
module bcd_stopwatch #(
    parameter int MIN_LIMIT = 59,
    parameter int TICK_SYNC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

    // ---------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic clr_meta_q, clr_sync_q;
    logic tick_sync_q, tick_prev_q;
    logic ss_edge, tick_edge, clear_s;

    // Two-stage synchronizers for the button levels plus the ss edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_meta_q  <= 1'b0;
            ss_sync_q  <= 1'b0;
            ss_prev_q  <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
        end else begin
            ss_meta_q  <= start_stop;
            ss_sync_q  <= ss_meta_q;
            ss_prev_q  <= ss_sync_q;
            clr_meta_q <= clear;
            clr_sync_q <= clr_meta_q;
        end
    end

    generate
        if (TICK_SYNC != 0) begin : g_tick_sync
            logic tick_meta_q;
            // Full 2-FF synchronizer for an asynchronous tick source.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    tick_meta_q <= 1'b0;
                    tick_sync_q <= 1'b0;
                end else begin
                    tick_meta_q <= tick_in;
                    tick_sync_q <= tick_meta_q;
                end
            end
        end else begin : g_tick_direct
            // Tick already synchronous: one register stage feeds the edge detector.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    tick_sync_q <= 1'b0;
                end else begin
                    tick_sync_q <= tick_in;
                end
            end
        end
    endgenerate

    // Tick edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_prev_q <= 1'b0;
        end else begin
            tick_prev_q <= tick_sync_q;
        end
    end

    assign ss_edge   = ss_sync_q & ~ss_prev_q;
    assign tick_edge = tick_sync_q & ~tick_prev_q;
    assign clear_s   = clr_sync_q;

    // ---------------------------------------------------------------
    // Count and FSM registers
    // ---------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       wrap_q, wrap_d;

    logic [3:0] n_so, n_st, n_mo, n_mt;
    logic       at_max;

    // State, digit and wrap registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            wrap_q     <= wrap_d;
        end
    end

    assign at_max = (sec_ones_q == 4'd9) && (sec_tens_q == 4'd5) &&
                    (min_ones_q == LIM_ONES) && (min_tens_q == LIM_TENS);

    // Incremented BCD value of the current count, including the rollover.
    always_comb begin
        n_so = sec_ones_q + 4'd1;
        n_st = sec_tens_q;
        n_mo = min_ones_q;
        n_mt = min_tens_q;
        if (at_max) begin
            n_so = 4'd0;
            n_st = 4'd0;
            n_mo = 4'd0;
            n_mt = 4'd0;
        end else if (sec_ones_q >= 4'd9) begin
            n_so = 4'd0;
            if (sec_tens_q >= 4'd5) begin
                n_st = 4'd0;
                if (min_ones_q >= 4'd9) begin
                    n_mo = 4'd0;
                    n_mt = min_tens_q + 4'd1;
                end else begin
                    n_mo = min_ones_q + 4'd1;
                end
            end else begin
                n_st = sec_tens_q + 4'd1;
            end
        end
    end

    // Next-state and next-count: clear dominates, only RUN advances on a tick.
    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clear_s) begin
            state_d    = S_IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    min_tens_d = 4'd0;
                    if (ss_edge) state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick_edge) begin
                        sec_ones_d = n_so;
                        sec_tens_d = n_st;
                        min_ones_d = n_mo;
                        min_tens_d = n_mt;
                        wrap_d     = at_max;
                    end
                    if (ss_edge) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (ss_edge) state_d = S_RUN;
                end
                default: begin
                    state_d    = S_IDLE;
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    min_tens_d = 4'd0;
                end
            endcase
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign running  = (state_q == S_RUN);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: a default instance (MIN_LIMIT=59,
// TICK_SYNC=1) and a small instance (MIN_LIMIT=1, TICK_SYNC=0).
// Inputs change on the falling clock edge; outputs are sampled #1 after a
// rising edge or on a falling edge.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic reset, tick_in, start_stop, clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic running, wrap;
    logic [15:0] disp;
    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    // Small instance
    logic reset2, tick2, ss2, clear2;
    logic [3:0] so2, st2, mo2, mt2;
    logic running2, wrap2;
    logic [15:0] disp2;
    assign disp2 = {mt2, mo2, st2, so2};

    int pass_cnt = 0;
    int total_cnt = 0;
    int wrap_cnt1 = 0;

    bcd_stopwatch #(.MIN_LIMIT(59), .TICK_SYNC(1)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens), .running(running), .wrap(wrap)
    );

    bcd_stopwatch #(.MIN_LIMIT(1), .TICK_SYNC(0)) dut2 (
        .clk(clk), .reset(reset2), .tick_in(tick2), .start_stop(ss2),
        .clear(clear2), .sec_ones(so2), .sec_tens(st2),
        .min_ones(mo2), .min_tens(mt2), .running(running2), .wrap(wrap2)
    );

    // Counts clocks with wrap high on the default instance.
    always @(posedge clk) begin
        #1;
        if (wrap === 1'b1) wrap_cnt1++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick1();
        @(negedge clk); tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic press1();
        @(negedge clk); start_stop = 1'b1;
        repeat (2) @(negedge clk);
        start_stop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear1();
        @(negedge clk); clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_b();
        @(negedge clk); tick2 = 1'b1;
        repeat (2) @(negedge clk);
        tick2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_b();
        @(negedge clk); ss2 = 1'b1;
        repeat (2) @(negedge clk);
        ss2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        tick2 = 1'b0; ss2 = 1'b0; clear2 = 1'b0;
        #2;
        reset = 1'b0; reset2 = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({disp, running, wrap} !== 18'h0) $display("FAIL reset_outputs: got %h expected %h", {disp, running, wrap}, 18'h0);
        else pass_cnt++;
        total_cnt++;
        if ({disp2, running2, wrap2} !== 18'h0) $display("FAIL reset_outputs2: got %h expected %h", {disp2, running2, wrap2}, 18'h0);
        else pass_cnt++;
        reset = 1'b1; reset2 = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({disp, running} !== 17'h0) $display("FAIL after_release: got %h expected %h", {disp, running}, 17'h0);
        else pass_cnt++;
    endtask

    task automatic test_idle_ticks();
        ticks1(5);
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL idle_ticks_disp: got %h expected %h", disp, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (running !== 1'b0) $display("FAIL idle_ticks_running: got %b expected %b", running, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_run_count();
        press1();
        total_cnt++;
        if (running !== 1'b1) $display("FAIL run_start: got %b expected %b", running, 1'b1);
        else pass_cnt++;
        // First tick: rise before edge k, count visible only after edge k+2.
        @(negedge clk); tick_in = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL tick_lat_k: got %h expected %h", disp, 16'h0000);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL tick_lat_k1: got %h expected %h", disp, 16'h0000);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (disp !== 16'h0001) $display("FAIL tick_lat_k2: got %h expected %h", disp, 16'h0001);
        else pass_cnt++;
        @(negedge clk); tick_in = 1'b0;
        repeat (2) @(negedge clk);
        ticks1(8);
        total_cnt++;
        if (disp !== 16'h0009) $display("FAIL count_9: got %h expected %h", disp, 16'h0009);
        else pass_cnt++;
        tick1();
        total_cnt++;
        if (disp !== 16'h0010) $display("FAIL carry_10: got %h expected %h", disp, 16'h0010);
        else pass_cnt++;
        ticks1(50);
        total_cnt++;
        if (disp !== 16'h0100) $display("FAIL carry_minute: got %h expected %h", disp, 16'h0100);
        else pass_cnt++;
        ticks1(15);
        total_cnt++;
        if ({disp, running} !== {16'h0115, 1'b1}) $display("FAIL count_0115: got %h expected %h", {disp, running}, {16'h0115, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_pause();
        clear1();
        total_cnt++;
        if ({disp, running} !== 17'h0) $display("FAIL clear_to_idle: got %h expected %h", {disp, running}, 17'h0);
        else pass_cnt++;
        // Held start_stop must act as a single edge.
        @(negedge clk); start_stop = 1'b1;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (running !== 1'b1) $display("FAIL ss_hold_a: got %b expected %b", running, 1'b1);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (running !== 1'b1) $display("FAIL ss_hold_b: got %b expected %b", running, 1'b1);
        else pass_cnt++;
        start_stop = 1'b0;
        repeat (3) @(negedge clk);
        ticks1(41);
        total_cnt++;
        if (disp !== 16'h0041) $display("FAIL count_0041: got %h expected %h", disp, 16'h0041);
        else pass_cnt++;
        // RUN with tick and ss together: increment applied, then PAUSE.
        @(negedge clk); tick_in = 1'b1; start_stop = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0; start_stop = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({disp, running} !== {16'h0042, 1'b0}) $display("FAIL run_tick_ss: got %h expected %h", {disp, running}, {16'h0042, 1'b0});
        else pass_cnt++;
        ticks1(10);
        total_cnt++;
        if ({disp, running} !== {16'h0042, 1'b0}) $display("FAIL pause_hold: got %h expected %h", {disp, running}, {16'h0042, 1'b0});
        else pass_cnt++;
        // PAUSE with tick and ss together: no increment, back to RUN.
        @(negedge clk); tick_in = 1'b1; start_stop = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0; start_stop = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({disp, running} !== {16'h0042, 1'b1}) $display("FAIL pause_tick_ss: got %h expected %h", {disp, running}, {16'h0042, 1'b1});
        else pass_cnt++;
        tick1();
        total_cnt++;
        if (disp !== 16'h0043) $display("FAIL resume_0043: got %h expected %h", disp, 16'h0043);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int w0;
        clear1();
        press1();
        ticks1(3599);
        total_cnt++;
        if ({disp, running} !== {16'h5959, 1'b1}) $display("FAIL count_5959: got %h expected %h", {disp, running}, {16'h5959, 1'b1});
        else pass_cnt++;
        w0 = wrap_cnt1;
        @(negedge clk); tick_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if ({disp, wrap} !== {16'h5959, 1'b0}) $display("FAIL wrap_k1: got %h expected %h", {disp, wrap}, {16'h5959, 1'b0});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({disp, wrap} !== {16'h0000, 1'b1}) $display("FAIL wrap_k2: got %h expected %h", {disp, wrap}, {16'h0000, 1'b1});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({wrap, running} !== 2'b01) $display("FAIL wrap_k3: got %b expected %b", {wrap, running}, 2'b01);
        else pass_cnt++;
        @(negedge clk); tick_in = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (wrap_cnt1 - w0 !== 1) $display("FAIL wrap_width: got %0d expected %0d", wrap_cnt1 - w0, 1);
        else pass_cnt++;
        tick1();
        total_cnt++;
        if (disp !== 16'h0001) $display("FAIL after_wrap: got %h expected %h", disp, 16'h0001);
        else pass_cnt++;
    endtask

    task automatic test_wrap_small();
        press_b();
        total_cnt++;
        if (running2 !== 1'b1) $display("FAIL small_run: got %b expected %b", running2, 1'b1);
        else pass_cnt++;
        // Synchronous tick path: count visible after edge k+1.
        @(negedge clk); tick2 = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (disp2 !== 16'h0000) $display("FAIL small_lat_k: got %h expected %h", disp2, 16'h0000);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (disp2 !== 16'h0001) $display("FAIL small_lat_k1: got %h expected %h", disp2, 16'h0001);
        else pass_cnt++;
        @(negedge clk); tick2 = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 118; i++) tick_b();
        total_cnt++;
        if (disp2 !== 16'h0159) $display("FAIL small_0159: got %h expected %h", disp2, 16'h0159);
        else pass_cnt++;
        @(negedge clk); tick2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if ({disp2, wrap2, running2} !== {16'h0000, 2'b11}) $display("FAIL small_wrap: got %h expected %h", {disp2, wrap2, running2}, {16'h0000, 2'b11});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (wrap2 !== 1'b0) $display("FAIL small_wrap_end: got %b expected %b", wrap2, 1'b0);
        else pass_cnt++;
        @(negedge clk); tick2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear_collision();
        int w0;
        clear1();
        press1();
        ticks1(754);
        total_cnt++;
        if (disp !== 16'h1234) $display("FAIL count_1234: got %h expected %h", disp, 16'h1234);
        else pass_cnt++;
        w0 = wrap_cnt1;
        @(negedge clk); clear = 1'b1; tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({disp, running} !== 17'h0) $display("FAIL clear_wins: got %h expected %h", {disp, running}, 17'h0);
        else pass_cnt++;
        clear = 1'b0; tick_in = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({disp, running} !== 17'h0) $display("FAIL clear_hold: got %h expected %h", {disp, running}, 17'h0);
        else pass_cnt++;
        total_cnt++;
        if (wrap_cnt1 !== w0) $display("FAIL clear_no_wrap: got %0d expected %0d", wrap_cnt1, w0);
        else pass_cnt++;
        tick1();
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL idle_after_clear: got %h expected %h", disp, 16'h0000);
        else pass_cnt++;
        press1();
        tick1();
        total_cnt++;
        if ({disp, running} !== {16'h0001, 1'b1}) $display("FAIL run_after_clear: got %h expected %h", {disp, running}, {16'h0001, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear1();
        press1();
        ticks1(187);
        total_cnt++;
        if (disp !== 16'h0307) $display("FAIL count_0307: got %h expected %h", disp, 16'h0307);
        else pass_cnt++;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({disp, running, wrap} !== 18'h0) $display("FAIL async_reset: got %h expected %h", {disp, running, wrap}, 18'h0);
        else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        tick1();
        total_cnt++;
        if ({disp, running} !== 17'h0) $display("FAIL idle_after_reset: got %h expected %h", {disp, running}, 17'h0);
        else pass_cnt++;
        press1();
        total_cnt++;
        if (running !== 1'b1) $display("FAIL run_after_reset: got %b expected %b", running, 1'b1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_run_count();
        test_pause();
        test_wrap();
        test_wrap_small();
        test_clear_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
